instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_instr_fetch_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC, issues in-order word fetches and buffers
// returned words with their PCs for decode. Optional IFETCH_PERF_EN adds
// perf_fetched / perf_stall counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
`ifdef IFETCH_PERF_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = 16;
    localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);

    logic [31:0]   r_pc;
    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [AW-1:0] r_fptr;
    logic [CW-1:0] r_count;
    logic [OW-1:0] r_outst;
    logic [OW-1:0] r_drop;
    logic          r_rst_q;

    logic [31:0]           r_buf_pc  [FIFO_DEPTH];
    logic [31:0]           r_buf_ins [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_buf_fill;

    logic          w_req_hs;
    logic          w_rsp;
    logic          w_rsp_fill;
    logic          w_pop;
    logic [OW-1:0] w_outst_nxt;
    logic [31:0]   w_redir_pc;

    // Requests only from registered occupancy; a same-cycle pop does not help.
    assign imem_req_valid = !rst && !r_rst_q && (r_count < DEPTH);
    assign imem_req_addr  = r_pc;

    assign out_valid = (r_count != '0) && r_buf_fill[r_head];
    assign out_ins   = r_buf_ins[r_head];
    assign out_pc    = r_buf_pc[r_head];

    assign w_req_hs    = imem_req_valid && imem_req_ready;
    assign w_rsp       = imem_rsp_valid && (r_outst != '0);
    assign w_rsp_fill  = w_rsp && (r_drop == '0);
    assign w_pop       = out_valid && out_ready && !redirect_valid;
    assign w_outst_nxt = r_outst + OW'(w_req_hs) - OW'(w_rsp);
    assign w_redir_pc  = redirect_pc & ~32'h3;

    // PC, pointers, occupancy and in-flight/drop bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_head  <= '0;
            r_tail  <= '0;
            r_fptr  <= '0;
            r_count <= '0;
            r_outst <= '0;
            r_drop  <= '0;
            r_rst_q <= 1'b1;
        end else begin
            r_rst_q <= 1'b0;
            r_outst <= w_outst_nxt;
            if (redirect_valid) begin
                r_pc    <= w_redir_pc;
                r_head  <= '0;
                r_tail  <= '0;
                r_fptr  <= '0;
                r_count <= '0;
                // Everything still in flight after this cycle is stale.
                r_drop  <= w_outst_nxt;
            end else begin
                if (w_req_hs) begin
                    r_pc   <= r_pc + 32'd4;
                    r_tail <= r_tail + 1'b1;
                end
                if (w_rsp_fill) begin
                    r_fptr <= r_fptr + 1'b1;
                end
                if (w_pop) begin
                    r_head <= r_head + 1'b1;
                end
                if (w_rsp && !w_rsp_fill) begin
                    r_drop <= r_drop - 1'b1;
                end
                r_count <= r_count + CW'(w_req_hs) - CW'(w_pop);
            end
        end
    end

    // Buffer entries: allocate at tail on request, fill oldest unfilled.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_buf_pc[i]  <= '0;
                r_buf_ins[i] <= '0;
            end
            r_buf_fill <= '0;
        end else if (!redirect_valid) begin
            if (w_req_hs) begin
                r_buf_pc[r_tail]   <= r_pc;
                r_buf_fill[r_tail] <= 1'b0;
            end
            if (w_rsp_fill) begin
                r_buf_ins[r_fptr]  <= imem_rsp_data;
                r_buf_fill[r_fptr] <= 1'b1;
            end
        end
    end

    // A response with nothing outstanding is a memory protocol error.
    always_ff @(posedge clk) begin
        if (!rst && imem_rsp_valid) begin
            assert (r_outst != '0);
        end
    end

`ifdef IFETCH_PERF_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;

    // Delivered-instruction and decode-starvation counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (out_valid && out_ready) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (out_ready && !out_valid) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: reset/streaming vector table plus directed
// backpressure, redirect, PC wrap and (IFETCH_PERF_EN) counter sequences.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_ins;
    logic [31:0] out_pc;

    logic        req2_valid;
    logic [31:0] req2_addr;
    logic        rsp2_valid = 1'b0;
    logic [31:0] rsp2_data = '0;
    logic        out2_valid;
    logic [31:0] out2_ins;
    logic [31:0] out2_pc;

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf2_fetched;
    logic [31:0] perf2_stall;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    int lat    = 1;
    int cyc    = 0;

    typedef struct {
        logic [31:0] a;
        int          due;
    } mreq_t;
    mreq_t mq[$];

    logic [31:0] got_pc[$];
    logic [31:0] got_ins[$];
    logic [31:0] req_q[$];
    logic [31:0] got2_pc[$];
    logic [31:0] got2_ins[$];

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
`ifdef IFETCH_PERF_EN
        .perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall),
`endif
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ins        (out_ins),
        .out_pc         (out_pc)
    );

    instr_fetch_unit #(
        .RESET_PC   (32'hFFFF_FFF8),
        .FIFO_DEPTH (4)
    ) dut2 (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (req2_valid),
        .imem_req_ready (1'b1),
        .imem_req_addr  (req2_addr),
        .imem_rsp_valid (rsp2_valid),
        .imem_rsp_data  (rsp2_data),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
`ifdef IFETCH_PERF_EN
        .perf_fetched   (perf2_fetched),
        .perf_stall     (perf2_stall),
`endif
        .out_valid      (out2_valid),
        .out_ready      (1'b1),
        .out_ins        (out2_ins),
        .out_pc         (out2_pc)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [63:0] expo(input logic [31:0] pc);
        return {pc, memf(pc)};
    endfunction

    function automatic logic [63:0] outp(input int i);
        if (i < got_pc.size()) return {got_pc[i], got_ins[i]};
        return 'x;
    endfunction

    function automatic logic [63:0] outp2(input int i);
        if (i < got2_pc.size()) return {got2_pc[i], got2_ins[i]};
        return 'x;
    endfunction

    function automatic logic [31:0] rq(input int i);
        if (i < req_q.size()) return req_q[i];
        return 'x;
    endfunction

    task automatic check(input string name, input logic [127:0] got,
                         input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Memory for dut: in-order, configurable latency in cycles.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            mq.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else begin
            if (imem_req_valid && imem_req_ready)
                mq.push_back('{imem_req_addr, cyc + lat - 1});
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= memf(mq[0].a);
                void'(mq.pop_front());
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    // Memory for dut2: always ready, one cycle latency.
    always @(posedge clk) begin
        if (rst) begin
            rsp2_valid <= 1'b0;
            rsp2_data  <= '0;
        end else begin
            rsp2_valid <= req2_valid;
            rsp2_data  <= memf(req2_addr);
        end
    end

    // Decode-side and request-side monitors.
    always @(posedge clk) begin
        if (!rst && out_valid && out_ready && !redirect_valid) begin
            got_pc.push_back(out_pc);
            got_ins.push_back(out_ins);
        end
        if (!rst && imem_req_valid && imem_req_ready)
            req_q.push_back(imem_req_addr);
        if (!rst && out2_valid) begin
            got2_pc.push_back(out2_pc);
            got2_ins.push_back(out2_ins);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        got_pc.delete();
        got_ins.delete();
        req_q.delete();
        got2_pc.delete();
        got2_ins.delete();
        rst = 1'b0;
    endtask

    task automatic wait_out(input int n, input string name);
        for (int k = 0; k < 80 && got_pc.size() < n; k++) @(negedge clk);
        check(name, 128'(got_pc.size() >= n), 128'(1));
    endtask

    typedef struct {
        logic        rst;
        logic        ord;
        logic        rv;
        logic [31:0] addr;
        logic        ov;
        logic [31:0] opc;
        logic [31:0] oins;
        logic        chkd;
    } vec_t;

    vec_t vt[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0;
        logic [95:0] g;
        logic [95:0] e;

        vt[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0,      1'b1};
        vt[1] = '{1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0,      1'b0};
        vt[2] = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0, 32'h0,      1'b0};
        vt[3] = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0, 32'h0,      1'b0};
        vt[4] = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0, memf(32'h0), 1'b1};
        vt[5] = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h4, memf(32'h4), 1'b1};
        vt[6] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, memf(32'h8), 1'b1};
        vt[7] = '{1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'hC, memf(32'hC), 1'b1};

        // Reset values and streaming start-up timing.
        lat = 1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            rst = vt[i].rst;
            out_ready = vt[i].ord;
            #1;
            g = {imem_req_valid, vt[i].rv ? imem_req_addr : 32'h0,
                 out_valid, vt[i].chkd ? out_pc : 32'h0,
                 vt[i].chkd ? out_ins : 32'h0};
            e = {vt[i].rv, vt[i].addr, vt[i].ov, vt[i].opc, vt[i].oins};
            check($sformatf("vec%0d", i), 128'(g), 128'(e));
        end

        // Backpressure: buffer fills at 4, then drains in order.
        out_ready = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        check("bp_req_count", 128'(req_q.size()), 128'(4));
        check("bp_req_valid_low", 128'(imem_req_valid), 128'(0));
        out_ready = 1'b1;
        wait_out(4, "bp_drain_timeout");
        for (int i = 0; i < 4; i++)
            check($sformatf("bp_out%0d", i), 128'(outp(i)),
                  128'(expo(32'(4 * i))));
        for (int k = 0; k < 20 && req_q.size() < 5; k++) @(negedge clk);
        check("bp_resume_addr", 128'(rq(4)), 128'(32'h10));

        // Redirect with two requests in flight (3-cycle memory).
        lat = 3;
        do_reset();
        for (int k = 0; k < 20 && req_q.size() < 2; k++) @(negedge clk);
        n0 = got_pc.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0102;
        imem_req_ready = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        check("rd1_next_addr", 128'({imem_req_valid, imem_req_addr}),
              128'({1'b1, 32'h100}));
        check("rd1_out_valid_low", 128'(out_valid), 128'(0));
        wait_out(n0 + 3, "rd1_timeout");
        check("rd1_req_after", 128'(rq(2)), 128'(32'h100));
        for (int i = 0; i < 3; i++)
            check($sformatf("rd1_out%0d", i), 128'(outp(n0 + i)),
                  128'(expo(32'h100 + 32'(4 * i))));

        // Redirect coinciding with a request handshake and a response.
        lat = 1;
        do_reset();
        repeat (6) @(negedge clk);
        check("rd2_setup",
              128'({imem_req_valid && imem_req_ready, imem_rsp_valid}),
              128'(2'b11));
        n0 = got_pc.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        check("rd2_out_valid_low", 128'(out_valid), 128'(0));
        wait_out(n0 + 2, "rd2_timeout");
        check("rd2_out0", 128'(outp(n0)), 128'(expo(32'h200)));
        check("rd2_out1", 128'(outp(n0 + 1)), 128'(expo(32'h204)));
        check("rd2_prev", 128'(outp(n0 - 1)),
              128'(expo(32'(4 * (n0 - 1)))));

        // Back-to-back redirects: only the last target survives.
        lat = 2;
        do_reset();
        repeat (5) @(negedge clk);
        n0 = got_pc.size();
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0301;
        @(negedge clk);
        redirect_pc = 32'h0000_0403;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_out(n0 + 2, "rd3_timeout");
        check("rd3_out0", 128'(outp(n0)), 128'(expo(32'h400)));
        check("rd3_out1", 128'(outp(n0 + 1)), 128'(expo(32'h404)));

        // PC wrap from RESET_PC = FFFF_FFF8 on the second instance.
        lat = 1;
        do_reset();
        for (int k = 0; k < 30 && got2_pc.size() < 3; k++) @(negedge clk);
        check("wrap_out0", 128'(outp2(0)), 128'(expo(32'hFFFF_FFF8)));
        check("wrap_out1", 128'(outp2(1)), 128'(expo(32'hFFFF_FFFC)));
        check("wrap_out2", 128'(outp2(2)), 128'(expo(32'h0000_0000)));

`ifdef IFETCH_PERF_EN
        // Five delivered instructions after three starved cycles.
        lat = 1;
        out_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 40 && got_pc.size() < 5; k++) @(negedge clk);
        out_ready = 1'b0;
        #1;
        check("perf_fetched", 128'(perf_fetched), 128'(5));
        check("perf_stall", 128'(perf_stall), 128'(3));
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("perf_rst", 128'({perf_fetched, perf_stall}), 128'(64'h0));
        rst = 1'b0;
        out_ready = 1'b1;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
